// File: rtl/ipf_lcu_feeder.sv
// rtl/ipf_lcu_feeder.sv - per-LCU parameter fetch and chunked pixel feed into the in-loop filter
module ipf_lcu_feeder #(
  parameter int WDOG = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  cfg_lcu_size,
  output logic        prm_req,
  input  logic        prm_valid,
  input  logic [23:0] prm_data,
  output logic        mem_rd,
  output logic [13:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        busy,
  input  logic        ipf_finish,
  output logic        in_en,
  output logic [7:0]  din,
  output logic [1:0]  ipf_type,
  output logic [4:0]  ipf_band_pos,
  output logic        ipf_wo_class,
  output logic [15:0] ipf_offset,
  output logic [2:0]  lcu_x,
  output logic [2:0]  lcu_y,
  output logic [1:0]  lcu_size,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRM, S_FEED, S_WAIT_HI, S_WAIT_LO, S_FIN_WAIT, S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  size_q;
  logic [5:0]  row, col, chunk;
  logic [9:0]  wdog;
  logic [5:0]  n_m1, chunk_last;
  logic [2:0]  l_m1;
  logic [6:0]  pix_y, pix_x;
  logic        chunk_end, lcu_last, wdog_hit;

  assign n_m1       = 6'((7'd16 << size_q) - 7'd1);
  assign chunk_last = 6'((7'd16 << size_q) - 7'd3);
  assign l_m1       = 3'((4'd8 >> size_q) - 4'd1);
  assign pix_y      = 7'({4'd0, lcu_y} << (3'd4 + {1'b0, size_q})) + {1'b0, row};
  assign pix_x      = 7'({4'd0, lcu_x} << (3'd4 + {1'b0, size_q})) + {1'b0, col};
  // Chunk 0 spans rows 0-2, every later chunk is a single row.
  assign chunk_end  = (col == n_m1) && (row >= 6'd2);
  assign lcu_last   = (lcu_x == l_m1) && (lcu_y == l_m1);
  assign wdog_hit   = (wdog == 10'(WDOG - 1));
  assign din        = in_en ? mem_data : 8'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    prm_req  = 1'b0;
    mem_rd   = 1'b0;
    mem_addr = 14'd0;
    case (state)
      S_IDLE:     if (start) state_nx = S_PRM;
      S_PRM: begin
        prm_req = 1'b1;
        if (prm_valid) state_nx = S_FEED;
      end
      S_FEED: begin
        mem_rd   = 1'b1;
        mem_addr = {pix_y, pix_x};
        if (chunk_end) state_nx = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (busy)          state_nx = S_WAIT_LO;
        else if (wdog_hit) state_nx = S_DONE;
      end
      S_WAIT_LO: begin
        if (!busy) begin
          if (chunk != chunk_last) state_nx = S_FEED;
          else if (lcu_last)       state_nx = S_FIN_WAIT;
          else                     state_nx = S_PRM;
        end
      end
      S_FIN_WAIT: if (ipf_finish) state_nx = S_DONE;
      S_DONE:     if (start) state_nx = S_PRM;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q       <= 2'd0;
      row          <= 6'd0;
      col          <= 6'd0;
      chunk        <= 6'd0;
      wdog         <= 10'd0;
      in_en        <= 1'b0;
      ipf_type     <= 2'd0;
      ipf_band_pos <= 5'd0;
      ipf_wo_class <= 1'b0;
      ipf_offset   <= 16'd0;
      lcu_x        <= 3'd0;
      lcu_y        <= 3'd0;
      lcu_size     <= 2'd0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      in_en <= mem_rd;
      if (state == S_WAIT_HI) wdog <= (wdog == 10'h3ff) ? wdog : wdog + 10'd1;
      else                    wdog <= 10'd0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            size_q <= (cfg_lcu_size == 2'd3) ? 2'd2 : cfg_lcu_size;
            lcu_x  <= 3'd0;
            lcu_y  <= 3'd0;
            row    <= 6'd0;
            col    <= 6'd0;
            chunk  <= 6'd0;
            done   <= 1'b0;
            err    <= 1'b0;
          end
        end
        S_PRM: begin
          if (prm_valid) begin
            ipf_type     <= prm_data[23:22];
            ipf_band_pos <= prm_data[21:17];
            ipf_wo_class <= prm_data[16];
            ipf_offset   <= prm_data[15:0];
            lcu_size     <= size_q;
          end
        end
        S_FEED: begin
          if (col == n_m1) begin
            col <= 6'd0;
            row <= row + 6'd1;
          end else begin
            col <= col + 6'd1;
          end
        end
        S_WAIT_HI: begin
          if (!busy && wdog_hit) begin
            err  <= 1'b1;
            done <= 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (!busy) begin
            if (chunk != chunk_last) begin
              chunk <= chunk + 6'd1;
            end else begin
              row   <= 6'd0;
              col   <= 6'd0;
              chunk <= 6'd0;
              if (!lcu_last) begin
                if (lcu_x == l_m1) begin
                  lcu_x <= 3'd0;
                  lcu_y <= lcu_y + 3'd1;
                end else begin
                  lcu_x <= lcu_x + 3'd1;
                end
              end
            end
          end
        end
        S_FIN_WAIT: if (ipf_finish) done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ipf_lcu_feeder.md
IPF_LCU_FEEDER -- requirements
Module: ipf_lcu_feeder

Interface
REQ-001 Parameter: WDOG, default 1023, max cycles spent in WAIT_HI before error.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-005 Port: cfg_lcu_size  in  2  LCU size (0:16, 1:32, 2:64); sampled with start; value 3 treated as 2.
REQ-006 Port: prm_req / prm_valid / prm_data  out 1 / in 1 / in 24  per-LCU parameter fetch; prm_data = {type[23:22], band_pos[21:17], wo_class[16], offset[15:0]}.
REQ-007 Port: mem_rd / mem_addr / mem_data  out 1 / out 14 / in 8  frame-memory read; 128x128 frame; data valid exactly 1 cycle after mem_rd.
REQ-008 Port: busy, ipf_finish  in 1 each  status from filter.
REQ-009 Port: in_en, din  out 1 / out 8  pixel stream to filter.
REQ-010 Port: ipf_type 2, ipf_band_pos 5, ipf_wo_class 1, ipf_offset 16, lcu_x 3, lcu_y 3, lcu_size 2  out  filter configuration.
REQ-011 Port: done, err  out 1 each  frame complete / watchdog error.

Function
REQ-012 N = 16<<size; LCUs per axis L = 8>>size; LCU order raster, lcu_x fastest, then lcu_y.
REQ-013 States: IDLE, PRM, FEED, WAIT_HI, WAIT_LO, FIN_WAIT, DONE.
REQ-014 IDLE: start -> PRM; latch size; lcu_x = lcu_y = 0; clear done, err.
REQ-015 PRM: prm_req held high until the cycle prm_valid=1; fields latched onto config outputs that cycle; next state FEED; prm_req low in the following cycle.
REQ-016 Config outputs and lcu_x/lcu_y/lcu_size stay stable from the PRM latch until the next PRM; valid on every cycle in_en=1.
REQ-017 FEED: one mem_rd per cycle in raster order within the LCU; mem_addr = (lcu_y*N+row)*128 + lcu_x*N + col, 14-bit.
REQ-018 in_en = mem_rd delayed 1 cycle; din = mem_data in that cycle; no gaps inside a chunk.
REQ-019 Chunk 0 of an LCU = rows 0-2 (3N pixels); each later chunk = one row; N-2 chunks per LCU.
REQ-020 After the last read of a chunk -> WAIT_HI; no mem_rd issued in WAIT_HI/WAIT_LO.
REQ-021 WAIT_HI: leave to WAIT_LO on first busy=1; watchdog counter increments per cycle; count = WDOG -> err=1, go to DONE.
REQ-022 WAIT_LO: busy=0 -> next chunk (FEED) if chunks remain; else advance LCU (lcu_x+1; at L-1 wrap to 0, lcu_y+1) -> PRM; after last LCU -> FIN_WAIT.
REQ-023 Busy seen high while in FEED is ignored (stall not permitted mid-chunk).
REQ-024 FIN_WAIT: ipf_finish=1 -> DONE; no watchdog here.
REQ-025 DONE: done=1 held until next start; start in DONE -> behaves as IDLE start (same cycle).
REQ-026 start outside IDLE/DONE ignored; prm_valid outside PRM ignored.
REQ-027 Row/col counters 6 bits; chunk counter 6 bits; watchdog 10 bits, saturating.

Reset
REQ-028 reset asserted (any state, including mid-chunk) -> IDLE immediately; all outputs 0: prm_req, mem_rd, mem_addr, in_en, din, config, lcu_x/y/size, done, err.
REQ-029 Pipelined in_en in flight at reset is dropped.

Verification
REQ-030 size=2, prm_valid 1 cycle after prm_req, filter model asserting busy 2 cycles after chunk: 4 LCUs, 62 chunks each; first chunk 192 in_en; total in_en 16384; done=1 after ipf_finish.
REQ-031 size=0, LCU (x=3,y=1): first mem_addr = 16*128+48 = 2096; last of chunk 0 = 18*128+63 = 2367.
REQ-032 prm_valid delayed 5 cycles -> prm_req high exactly 6 cycles, no mem_rd meanwhile; config values equal to the prm_data word.
REQ-033 busy never asserted after chunk -> err=1, state DONE, exactly WDOG cycles after entering WAIT_HI.
REQ-034 reset pulse mid-chunk (pixel 100 of size 1) -> same-cycle in_en=0, mem_rd=0; a new start restarts at mem_addr 0 with a fresh prm_req.
REQ-035 size=1 wrap: after LCU (3,0) the next prm_req shows lcu_x=0, lcu_y=1; 16 LCUs total before FIN_WAIT.
